// File: rtl/broken_clause_collector_pkg.sv
// Shared widths, defaults and FSM encoding for the broken-clause collector slice.
package broken_clause_collector_pkg;

    localparam int unsigned NSAT                     = 3;
    localparam int unsigned LITERAL_ADDRESS_WIDTH    = 11;
    localparam int unsigned MAX_CLAUSES_PER_VARIABLE = 20;
    localparam int unsigned SLOT_BITS                = 5;
    localparam int unsigned FIFO_DEPTH               = 16;
    localparam int unsigned FIFO_ADDR_BITS           = 4;

    localparam int unsigned LITERAL_WIDTH = LITERAL_ADDRESS_WIDTH + 1;
    localparam int unsigned CLAUSE_WIDTH  = NSAT * LITERAL_WIDTH;
    localparam int unsigned BUNDLE_WIDTH  = CLAUSE_WIDTH * MAX_CLAUSES_PER_VARIABLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } collector_state_t;

endpackage

// File: rtl/broken_clause_collector_clause_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module clause_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       ready,
    output logic [WIDTH-1:0]           data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned ADDR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [WIDTH-1:0]     held;
    logic                 do_push;
    logic                 do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (ADDR_BITS+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = valid && ready && !flush;

    // When empty, keep presenting whatever the head showed last cycle.
    assign data = valid ? mem[rd_ptr] : held;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            held   <= data;
        end else begin
            held <= data;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/broken_clause_collector.sv
// Compacts the broken, non-empty clauses of a captured bundle into a FIFO, one slot per cycle.
module broken_clause_collector
    import broken_clause_collector_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_i,
    input  logic [BUNDLE_WIDTH-1:0]             clause_multi_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] broken_mask_i,
    input  logic                                flush_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [CLAUSE_WIDTH-1:0]             clause_o,
    output logic                                clause_valid_o,
    input  logic                                clause_ready_i,
    output logic [FIFO_ADDR_BITS:0]             fifo_count_o,
    output logic [15:0]                         stall_count_o
);

    collector_state_t                    state;
    collector_state_t                    state_next;
    logic [BUNDLE_WIDTH-1:0]             bundle_q;
    logic [MAX_CLAUSES_PER_VARIABLE-1:0] pending_q;
    logic [MAX_CLAUSES_PER_VARIABLE-1:0] pending_next;
    logic [MAX_CLAUSES_PER_VARIABLE-1:0] nonempty;
    logic [MAX_CLAUSES_PER_VARIABLE-1:0] lowest;
    logic [SLOT_BITS-1:0]                sel;
    logic [CLAUSE_WIDTH-1:0]             push_data;
    logic [15:0]                         stall_q;
    logic                                push;
    logic                                capture;
    logic                                stall_inc;
    logic                                fifo_full;

    always_comb begin
        nonempty = '0;
        for (int unsigned i = 0; i < MAX_CLAUSES_PER_VARIABLE; i++) begin
            nonempty[i] = |clause_multi_i[i*CLAUSE_WIDTH +: LITERAL_WIDTH];
        end
    end

    // Lowest pending slot wins; scanning downward leaves the smallest index in sel.
    always_comb begin
        sel = '0;
        for (int unsigned i = MAX_CLAUSES_PER_VARIABLE; i > 0; i--) begin
            if (pending_q[i-1]) begin
                sel = SLOT_BITS'(i - 1);
            end
        end
    end

    assign lowest    = pending_q & (~pending_q + 1'b1);
    assign push_data = bundle_q[sel*CLAUSE_WIDTH +: CLAUSE_WIDTH];

    always_comb begin
        state_next   = state;
        pending_next = pending_q;
        push         = 1'b0;
        capture      = 1'b0;
        stall_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (load_i) begin
                    capture      = 1'b1;
                    pending_next = broken_mask_i & nonempty;
                    state_next   = SCAN;
                end
            end
            SCAN: begin
                if (pending_q == '0) begin
                    state_next = DONE;
                end else if (!fifo_full) begin
                    push         = 1'b1;
                    pending_next = pending_q & ~lowest;
                    if ((pending_q & ~lowest) == '0) begin
                        state_next = DONE;
                    end
                end else begin
                    stall_inc = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next   = IDLE;
            pending_next = '0;
            push         = 1'b0;
            capture      = 1'b0;
            stall_inc    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            bundle_q  <= '0;
            stall_q   <= '0;
        end else begin
            state     <= state_next;
            pending_q <= pending_next;
            if (capture) begin
                bundle_q <= clause_multi_i;
            end
            if (stall_inc && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    clause_fifo #(
        .WIDTH (CLAUSE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_i),
        .push      (push),
        .push_data (push_data),
        .ready     (clause_ready_i),
        .data      (clause_o),
        .valid     (clause_valid_o),
        .full      (fifo_full),
        .count     (fifo_count_o)
    );

    assign busy_o        = (state != IDLE);
    assign done_o        = (state == DONE);
    assign stall_count_o = stall_q;

endmodule

// File: doc/broken_clause_collector.md
Name: broken_clause_collector

Overview:
- Downstream consumer of the per-variable temporal buffer bank. Takes the MAX_CLAUSES_PER_VARIABLE-clause bundle produced for the selected flip, plus a per-slot "now broken" mask from the break evaluator.
- Compacts the broken clauses into a FIFO of single clauses, one slot per cycle. The FIFO feeds the unsatisfied-clause list over a valid/ready interface.

Parameters:
- NSAT, 3, literals per clause
- LITERAL_ADDRESS_WIDTH, 11, literal address bits; each literal field is LITERAL_ADDRESS_WIDTH+1 bits wide
- MAX_CLAUSES_PER_VARIABLE, 20, clause slots per bundle
- SLOT_BITS, 5, bits to index a slot; must satisfy 2^SLOT_BITS >= MAX_CLAUSES_PER_VARIABLE
- FIFO_DEPTH, 16, output FIFO entries; must be a power of two
- FIFO_ADDR_BITS, 4, log2(FIFO_DEPTH)

Ports:
- clk, input, 1, clock
- reset, input, 1, synchronous active-high reset
- load_i, input, 1, capture bundle and mask; honoured only when busy_o=0
- clause_multi_i, input, NSAT*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1), slot i at bits [i*NSAT*(LITERAL_ADDRESS_WIDTH+1) +: NSAT*(LITERAL_ADDRESS_WIDTH+1)]
- broken_mask_i, input, MAX_CLAUSES_PER_VARIABLE, bit i=1 means slot i is broken
- flush_i, input, 1, abort scan and empty FIFO
- busy_o, output, 1, scan in progress
- done_o, output, 1, one-cycle pulse when scan completes
- clause_o, output, NSAT*(LITERAL_ADDRESS_WIDTH+1), FIFO head clause
- clause_valid_o, output, 1, FIFO non-empty
- clause_ready_i, input, 1, consumer accepts head
- fifo_count_o, output, FIFO_ADDR_BITS+1, current occupancy
- stall_count_o, output, 16, saturating count of SCAN cycles stalled on a full FIFO

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: state=IDLE, pending mask=0, FIFO empty.
  - Outputs: busy_o=0, done_o=0, clause_valid_o=0, fifo_count_o=0, stall_count_o=0, clause_o=0.
- Empty slot: a slot whose literal 0 field is all-zero is empty. It is excluded from pending regardless of its broken bit.
- IDLE:
  - load_i=1 registers the bundle and sets pending = broken_mask_i AND non-empty-slot vector.
  - Next state is SCAN.
- SCAN, each cycle:
  - sel = lowest set bit of pending.
  - If FIFO not full: push clause[sel] and clear pending[sel].
  - If FIFO full: no push, pending unchanged, stall_count_o increments (saturates at 16'hFFFF).
  - Go to DONE when the bit just cleared was the last one set, or when pending==0 on entry.
- DONE: done_o=1 for exactly this cycle, then IDLE.
- busy_o=1 in SCAN and DONE.
- load_i while busy_o=1 is ignored; no capture, no error.
- Timing, with load_i accepted in cycle 0 and no stalls:
  - k>=1 broken slots: pushes occur in cycles 1..k, done_o is high in cycle k+1, a new load is accepted from cycle k+2.
  - k=0: done_o is high in cycle 2.
- FIFO:
  - First-word-fall-through. clause_o = head, clause_valid_o = (count!=0).
  - Pop when clause_valid_o && clause_ready_i.
  - Push into a full FIFO is never performed. Fullness is judged on the registered count, so a same-cycle pop does not free space for that cycle's push.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - clause_o is undefined-but-stable when empty; drive the last head value.
- flush_i (lower priority than reset, higher than everything else):
  - Next cycle: FIFO empty, pending=0, state=IDLE, done_o=0.
  - A load_i in the same cycle is ignored.
  - stall_count_o is not cleared.
- Ordering: clauses leave the FIFO in ascending slot order within a bundle. Bundles are never interleaved.

Decomposition:
- Shared package holds:
  - LITERAL_WIDTH = LITERAL_ADDRESS_WIDTH+1
  - CLAUSE_WIDTH = NSAT*LITERAL_WIDTH
  - BUNDLE_WIDTH
  - state encodings IDLE/SCAN/DONE
- One natural sub-module: clause_fifo, a synchronous FWFT FIFO parameterised by width and depth, with count output.
- The priority encoder stays inline.

Test Plan:
- Mask 20'h00005, slots 0 and 2 non-empty, ready=1, load in cycle 0 -> clause_o shows slot0 then slot2; done_o high in cycle 3; fifo_count_o returns to 0.
- Mask 20'h00000 -> no push; done_o high in cycle 2; busy_o high in cycles 1-2.
- Mask 20'hFFFFF, ready=0, FIFO_DEPTH=16 -> count reaches 16; stall_count_o increments each cycle after that. Raising ready then drains all 20 clauses in slot order 0..19, and done_o follows the 20th push.
- Mask 20'h00009 with slot 3 literal-0 field = 0 -> only slot 0 is pushed; done_o in cycle 2.
- load_i asserted during SCAN with a different bundle -> ignored; output matches the first bundle only.
- flush_i mid-scan with 3 entries queued -> next cycle fifo_count_o=0, busy_o=0, no done_o; a new load then completes normally.
